// File: rtl/mult32_pkg.sv
// Shared data-path definitions for the signed multiplier and its helpers.
`default_nettype none

package mult32_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int DATA_MSB   = DATA_WIDTH - 1;
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int PROD_MSB   = PROD_WIDTH - 1;

  // Two's-complement magnitude; the most negative value wraps to itself,
  // which is exactly 2^(N-1) when the result is read as unsigned.
  function automatic logic [DATA_MSB:0] magnitude(input logic [DATA_MSB:0] x);
    return x[DATA_MSB] ? (~x + 1'b1) : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult32_u.sv
// Combinational unsigned DATA_WIDTH x DATA_WIDTH multiplier built from
// shift-and-add partial-product rows.
`default_nettype none

module mult32_u
  import mult32_pkg::*;
(
  input  logic [DATA_MSB:0] a,
  input  logic [DATA_MSB:0] b,
  output logic [PROD_MSB:0] p
);

  logic [PROD_MSB:0] rows [DATA_WIDTH];

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_row
    assign rows[i] = b[i] ? ({{DATA_WIDTH{1'b0}}, a} << i) : '0;
  end

  always_comb begin
    p = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      p = p + rows[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult32.sv
// Signed 32x32 multiplier with registered 64-bit HI/LO result and a
// one-cycle valid strobe; feeds the HI/LO special registers for MULT.
`default_nettype none

module mult32
  import mult32_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_MSB:0] A,
  input  logic [DATA_MSB:0] B,
  input  logic              VALID_IN,
  output logic [DATA_MSB:0] HI,
  output logic [DATA_MSB:0] LO,
  output logic              VALID_OUT
);

  logic [DATA_MSB:0] mag_a;
  logic [DATA_MSB:0] mag_b;
  logic [PROD_MSB:0] prod_u;
  logic [PROD_MSB:0] prod_s;
  logic              neg_result;

  assign mag_a      = magnitude(A);
  assign mag_b      = magnitude(B);
  assign neg_result = A[DATA_MSB] ^ B[DATA_MSB];

  mult32_u u_mult (
    .a (mag_a),
    .b (mag_b),
    .p (prod_u)
  );

  // A zero magnitude product negates to zero, so no special case is needed.
  assign prod_s = neg_result ? (~prod_u + 1'b1) : prod_u;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      HI        <= '0;
      LO        <= '0;
      VALID_OUT <= 1'b0;
    end else begin
      VALID_OUT <= VALID_IN;
      if (VALID_IN) begin
        HI <= prod_s[PROD_MSB:DATA_WIDTH];
        LO <= prod_s[DATA_MSB:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult32.sv
// Directed and randomised self-checking bench for the signed multiplier.
`default_nettype none

module tb_mult32;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] A;
  logic [31:0] B;
  logic        VALID_IN;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        VALID_OUT;

  int n_cmp  = 0;
  int n_fail = 0;

  mult32 dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .VALID_IN  (VALID_IN),
    .HI        (HI),
    .LO        (LO),
    .VALID_OUT (VALID_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic ev);
    n_cmp++;
    assert ({HI, LO, VALID_OUT} === {ehi, elo, ev}) else begin
      n_fail++;
      $error("FAIL %s: got HI=%h LO=%h V=%b, want HI=%h LO=%h V=%b",
             tag, HI, LO, VALID_OUT, ehi, elo, ev);
    end
  endtask

  // Called at a falling edge: launch at the next rising edge, check at the
  // following falling edge; VALID_IN is left low so a later call may chain.
  task automatic launch(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    A = a;
    B = b;
    VALID_IN = 1'b1;
    @(negedge CLK);
    VALID_IN = 1'b0;
    check(tag, ehi, elo, 1'b1);
  endtask

  initial begin
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [63:0] r;

    RST = 1'b0;
    A = '0;
    B = '0;
    VALID_IN = 1'b0;
    #1;
    check("reset_initial", 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("idle_after_reset", 32'h0, 32'h0, 1'b0);

    launch("3x3", 32'd3, 32'd3, 32'h0, 32'h9);
    @(negedge CLK);
    check("pulse_drop", 32'h0, 32'h9, 1'b0);
    launch("9x9", 32'd9, 32'd9, 32'h0, 32'h51);
    @(negedge CLK);

    launch("m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
    launch("1xm1", 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    launch("0xm1", 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0);
    launch("negneg_a", 32'hFF000000, 32'hEEEEEEEE, 32'h00111111, 32'h12000000);
    launch("negneg_b", 32'hF0000000, 32'hF0000001, 32'h00FFFFFF, 32'hF0000000);
    launch("min_x_min", 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    launch("min_x_1", 32'h80000000, 32'h1, 32'hFFFFFFFF, 32'h80000000);
    launch("min_x_m1", 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    @(negedge CLK);

    // Back-to-back launches, then idle hold.
    launch("b2b_0", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2);
    launch("b2b_1", 32'h00010000, 32'h00010000, 32'h1, 32'h0);
    launch("b2b_2", 32'd1000, 32'd1000, 32'h0, 32'h000F4240);
    @(negedge CLK);
    check("hold_after_b2b", 32'h0, 32'h000F4240, 1'b0);

    // Operands moving after the sampling edge must not disturb the result.
    A = 32'd5;
    B = 32'd6;
    VALID_IN = 1'b1;
    @(posedge CLK);
    #1;
    VALID_IN = 1'b0;
    A = 32'd100;
    B = 32'd100;
    @(negedge CLK);
    check("sample_edge_only", 32'h0, 32'd30, 1'b1);

    // Asynchronous reset with a result in flight.
    launch("pre_reset", 32'd12, 32'd12, 32'h0, 32'd144);
    RST = 1'b0;
    #1;
    check("reset_async", 32'h0, 32'h0, 1'b0);
    #2;
    RST = 1'b1;
    @(negedge CLK);
    check("reset_hold", 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      sa = $signed($urandom);
      sb = $signed($urandom);
      r  = sa * sb;
      launch("random", sa, sb, r[63:32], r[31:0]);
    end
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
